main_decoder: RTL and testbench
===============================

Name: main_decoder

Overview:
- Main control decoder of the single-cycle RV32I core.
- Combinationally maps the 7-bit instruction opcode to datapath control: register write, immediate format, ALU operand select, memory write, result mux select, branch, jump and ALU-decoder class.
- Also provides an illegal-opcode flag and a sticky, reset-cleared illegal-opcode status register for debug.

Parameters:
- none

Ports:
- clk  input  1  system clock; only the sticky status register uses it
- rst_n  input  1  asynchronous active-low reset
- Opcode  input  7  instruction bits [6:0]
- RegWrite  output  1  register file write enable
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- ALUSrc  output  1  ALU operand B select: 0 register, 1 immediate
- MemWrite  output  1  data memory write enable
- ResultSrc  output  2  writeback select: 00 ALU result, 01 memory read data, 10 PC+4
- Branch  output  1  conditional branch instruction
- Jump  output  1  unconditional jump instruction
- ALUOp  output  2  ALU decoder class: 00 add, 01 subtract/compare, 10 decode funct3/funct7
- illegal_op  output  1  combinational; Opcode is not one of the six supported values
- illegal_seen  output  1  registered sticky flag

Behaviour:
- All control outputs and illegal_op are purely combinational from Opcode.
  - Zero latency.
  - Independent of clk and rst_n.
  - No don't-cares: every bit is driven to a defined value for every opcode.
- Decode, listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump:
  - 0000011 load (lw): 1, 00, 1, 0, 01, 0, 00, 0
  - 0100011 store (sw): 0, 01, 1, 1, 00, 0, 00, 0
  - 0110011 R-type: 1, 00, 0, 0, 00, 0, 10, 0
  - 1100011 branch (beq): 0, 10, 0, 0, 00, 1, 01, 0
  - 0010011 I-type ALU: 1, 00, 1, 0, 00, 0, 10, 0
  - 1101111 jal: 1, 11, 0, 0, 10, 0, 00, 1
  - any other value (including X/Z, 0000000, 1111111): every control output 0 and illegal_op = 1
- illegal_op = 0 for exactly the six supported opcodes.
- illegal_seen:
  - Cleared to 0 asynchronously whenever rst_n = 0.
  - While rst_n = 1, set to 1 on any rising clk edge where illegal_op = 1.
  - Stays 1 until the next reset; no other clear path.
- Reset-value summary: illegal_seen = 0. Combinational outputs follow Opcode even during reset.
- At most one of MemWrite, Branch, Jump is 1 for any opcode.
- MemWrite = 1 implies RegWrite = 0.

Test Plan:
- Sweep the six supported opcodes at 5-unit spacing with no clock, e.g. 0000011 then 0100011, 0110011, 1100011, 0010011, 1101111. Each step must produce exactly its decode-table row within the same timestep. Spot checks: 0000011 gives ResultSrc = 01, ALUSrc = 1, RegWrite = 1; 1101111 gives Jump = 1, ImmSrc = 11, ResultSrc = 10.
- Opcode = 1111111 -> all controls 0, illegal_op = 1. Then Opcode = 0110011 -> illegal_op = 0, RegWrite = 1, ALUOp = 10.
- Hold rst_n = 0 and drive 1111111 while clocking -> illegal_seen stays 0. Release rst_n and apply one rising edge -> illegal_seen = 1. Return to a legal opcode -> illegal_seen remains 1.
- With illegal_seen = 1, assert rst_n = 0 between clock edges -> illegal_seen = 0 immediately, without waiting for a clock edge.
- Exhaustive sweep of all 128 opcodes -> exactly 6 values give illegal_op = 0. No opcode asserts more than one of MemWrite, Branch, Jump. MemWrite = 1 never occurs with RegWrite = 1.

Source files
------------

// File: rtl/main_decoder.sv
// Main control decoder for the single-cycle RV32I core: opcode -> datapath controls,
// plus a sticky illegal-opcode status bit for debug.
module main_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic       Branch,
    output logic       Jump,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic       illegal_seen
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Every output defaults to 0 so unsupported (or unknown) opcodes are inert.
    always_comb begin
        RegWrite   = 1'b0;
        ImmSrc     = 2'b00;
        ALUSrc     = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = 2'b00;
        Branch     = 1'b0;
        Jump       = 1'b0;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;
        case (Opcode)
            OP_LOAD: begin
                RegWrite  = 1'b1;
                ImmSrc    = 2'b00;
                ALUSrc    = 1'b1;
                ResultSrc = 2'b01;
            end
            OP_STORE: begin
                ImmSrc   = 2'b01;
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            OP_RTYPE: begin
                RegWrite = 1'b1;
                ALUOp    = 2'b10;
            end
            OP_BRANCH: begin
                ImmSrc = 2'b10;
                Branch = 1'b1;
                ALUOp  = 2'b01;
            end
            OP_ITYPE: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = 2'b10;
            end
            OP_JAL: begin
                RegWrite  = 1'b1;
                ImmSrc    = 2'b11;
                ResultSrc = 2'b10;
                Jump      = 1'b1;
            end
            default: illegal_op = 1'b1;
        endcase
    end

    // Sticky: only a reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen <= 1'b0;
        end else if (illegal_op) begin
            illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_main_decoder.sv
// Directed bench for main_decoder: decode table, illegal opcodes, exhaustive
// invariants and the sticky illegal_seen register with its async clear.
module tb_main_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] Opcode;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic       ALUSrc;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic       Branch;
    logic       Jump;
    logic [1:0] ALUOp;
    logic       illegal_op;
    logic       illegal_seen;

    int checks_total;
    int checks_passed;

    logic [10:0] ctl;
    assign ctl = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump};

    main_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (Opcode),
        .RegWrite    (RegWrite),
        .ImmSrc      (ImmSrc),
        .ALUSrc      (ALUSrc),
        .MemWrite    (MemWrite),
        .ResultSrc   (ResultSrc),
        .Branch      (Branch),
        .Jump        (Jump),
        .ALUOp       (ALUOp),
        .illegal_op  (illegal_op),
        .illegal_seen(illegal_seen)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // directed table: opcode and hand-written control word
    // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump}
    logic [6:0]  vec_op  [6];
    logic [10:0] vec_ctl [6];
    string       vec_name[6];

    initial begin
        vec_op[0] = 7'b0000011; vec_ctl[0] = 11'b1_00_1_0_01_0_00_0; vec_name[0] = "lw";
        vec_op[1] = 7'b0100011; vec_ctl[1] = 11'b0_01_1_1_00_0_00_0; vec_name[1] = "sw";
        vec_op[2] = 7'b0110011; vec_ctl[2] = 11'b1_00_0_0_00_0_10_0; vec_name[2] = "rtype";
        vec_op[3] = 7'b1100011; vec_ctl[3] = 11'b0_10_0_0_00_1_01_0; vec_name[3] = "beq";
        vec_op[4] = 7'b0010011; vec_ctl[4] = 11'b1_00_1_0_00_0_10_0; vec_name[4] = "itype";
        vec_op[5] = 7'b1101111; vec_ctl[5] = 11'b1_11_0_0_10_0_00_1; vec_name[5] = "jal";
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int legal_count;
        logic is_legal;
        checks_total  = 0;
        checks_passed = 0;
        rst_n  = 1'b0;
        Opcode = 7'b0000000;
        #1;
        check("reset_illegal_seen", {31'd0, illegal_seen}, 32'd0);
        check("op0_illegal", {31'd0, illegal_op}, 32'd1);
        check("op0_ctl", {21'd0, ctl}, 32'd0);

        // supported opcode sweep, 5-unit spacing
        for (int i = 0; i < 6; i++) begin
            Opcode = vec_op[i];
            #1;
            check({vec_name[i], "_ctl"}, {21'd0, ctl}, {21'd0, vec_ctl[i]});
            check({vec_name[i], "_illegal"}, {31'd0, illegal_op}, 32'd0);
            if (i == 0) begin
                check("lw_resultsrc", {30'd0, ResultSrc}, 32'd1);
                check("lw_alusrc", {31'd0, ALUSrc}, 32'd1);
                check("lw_regwrite", {31'd0, RegWrite}, 32'd1);
            end
            if (i == 5) begin
                check("jal_jump", {31'd0, Jump}, 32'd1);
                check("jal_immsrc", {30'd0, ImmSrc}, 32'd3);
                check("jal_resultsrc", {30'd0, ResultSrc}, 32'd2);
            end
            #4;
        end

        // all-ones then back to R-type
        Opcode = 7'b1111111;
        #1;
        check("ones_ctl", {21'd0, ctl}, 32'd0);
        check("ones_illegal", {31'd0, illegal_op}, 32'd1);
        #4;
        Opcode = 7'b0110011;
        #1;
        check("rt_illegal", {31'd0, illegal_op}, 32'd0);
        check("rt_regwrite", {31'd0, RegWrite}, 32'd1);
        check("rt_aluop", {30'd0, ALUOp}, 32'd2);
        #4;

        // exhaustive sweep (reset still held, so illegal_seen must not move)
        legal_count = 0;
        for (int i = 0; i < 128; i++) begin
            Opcode = i[6:0];
            #1;
            is_legal = 1'b0;
            for (int k = 0; k < 6; k++) begin
                if (vec_op[k] == i[6:0]) is_legal = 1'b1;
            end
            if (!illegal_op) legal_count++;
            check("sweep_illegal", {31'd0, illegal_op}, {31'd0, ~is_legal});
            if (!is_legal) check("sweep_zero_ctl", {21'd0, ctl}, 32'd0);
            check("sweep_excl", {31'd0, ($countones({MemWrite, Branch, Jump}) <= 1)}, 32'd1);
            check("sweep_mw_rw", {31'd0, MemWrite & RegWrite}, 32'd0);
            #1;
        end
        check("legal_count", legal_count, 32'd6);

        // sticky register: illegal opcode under reset must not set it
        @(negedge clk);
        Opcode = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        check("held_reset_seen", {31'd0, illegal_seen}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("seen_set", {31'd0, illegal_seen}, 32'd1);
        @(negedge clk);
        Opcode = 7'b0010011;
        repeat (2) @(posedge clk);
        #1;
        check("seen_sticky", {31'd0, illegal_seen}, 32'd1);

        // async clear between edges
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("seen_async_clear", {31'd0, illegal_seen}, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("seen_legal_stays0", {31'd0, illegal_seen}, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
